weight2_row_loader: RTL and testbench
=====================================

WEIGHT2_ROW_LOADER -- requirements
Module: weight2_row_loader

Interface
REQ-001 Parameter DW, default 16: weight word width in bits.
REQ-002 Parameter ROW_LEN, default 10: words per weight-2 row.
REQ-003 Parameter NUM_ROWS, default 200: rows per full weight-2 load.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port in_valid, input, 1: in_data holds a valid weight word.
REQ-007 Port in_ready, output, 1: loader accepts the word this cycle.
REQ-008 Port in_data, input, DW: next weight word, row-major, element 0 first.
REQ-009 Port load_next_row, input, 1: one-cycle pulse from the weight-2 consumer releasing the current row.
REQ-010 Port row_valid, output, 1: row_data holds a complete row.
REQ-011 Port row_data, output, ROW_LEN*DW: active row; element k in bits [k*DW +: DW].
REQ-012 Port row_index, output, 8: index of the active row, 0..NUM_ROWS-1.
REQ-013 Port done, output, 1: all NUM_ROWS rows have been released.
REQ-014 Port err, output, 1: sticky flag; load_next_row arrived while row_valid=0.

Function
REQ-015 A transfer occurs on any cycle with in_valid=1 and in_ready=1; the word is written to shadow slot wcnt, and wcnt increments.
REQ-016 in_ready SHALL be 1 only when the shadow row is not full, fewer than NUM_ROWS rows have been fetched, and done=0.
REQ-017 The shadow row becomes full on the transfer with wcnt=ROW_LEN-1; wcnt then wraps to 0.
REQ-018 State EMPTY (row_valid=0, shadow not full): on shadow full, go to ACTIVE on the next edge; active takes the shadow contents, and row_valid rises.
REQ-019 Latency: if the first word of a row is accepted at cycle 0 into an EMPTY loader and words are back-to-back, row_valid=1 at cycle ROW_LEN.
REQ-020 State ACTIVE (row_valid=1, shadow filling): load_next_row with the shadow not full -> EMPTY, row_valid=0; shadow filling continues.
REQ-021 ACTIVE and shadow fills with no load_next_row -> FULL; in_ready=0.
REQ-022 State FULL: load_next_row -> swap on the next edge; row_valid stays 1 with no bubble, row_index+1, and the shadow is freed.
REQ-023 Simultaneous events: load_next_row on the same cycle as the final shadow word in ACTIVE -> swap as in REQ-022 (no EMPTY cycle).
REQ-024 row_index SHALL increment by 1 on each swap after the first; the first row presented is index 0.
REQ-025 On release of row NUM_ROWS-1, go to DONE: row_valid=0, done=1, in_ready=0; hold until reset.
REQ-026 load_next_row while row_valid=0, including in DONE: ignored, and err is set to 1 until reset.
REQ-027 in_data SHALL be ignored whenever in_ready=0; a word with in_valid=1 and in_ready=0 is not consumed.

Reset
REQ-028 While reset=0 at a clock edge, the following SHALL be cleared:
- state=EMPTY
- wcnt=0, rows-fetched count=0
- in_ready=0, row_valid=0, row_data=0, row_index=0, done=0, err=0
REQ-029 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 Reset mid-row SHALL discard partial shadow contents; the load restarts at row 0, word 0.

Structure
REQ-031 A shared package SHALL hold DW, ROW_LEN, NUM_ROWS and the state enum {EMPTY, ACTIVE, FULL, DONE}.
REQ-032 Storage SHALL be a sub-module w2_row_bank: a shadow register file with indexed write plus a whole-row copy into the active register.
REQ-033 Control (FSM, wcnt, row counters) SHALL reside in weight2_row_loader.

Verification
REQ-034 Reset, then 10 back-to-back words 0x0001..0x000A -> row_valid=1 ten cycles after the first accept; row_data element k = k+1; row_index=0.
REQ-035 Stream 20 words, no load_next_row -> state FULL; in_ready=0 after word 20; row_data still holds row 0.
REQ-036 From FULL, pulse load_next_row -> next cycle row_index=1, row_valid stays 1, row_data = row 1, in_ready=1.
REQ-037 Pulse load_next_row on the cycle the 10th shadow word is accepted -> no row_valid=0 cycle; row_index increments.
REQ-038 Full load of 2000 words with a release after each row -> done=1 after release of row_index=199; in_ready=0; err=0.
REQ-039 Assert reset=0 after word 5 of row 3, then reload -> row_index=0, and the first row equals the new data; pulse load_next_row while EMPTY -> err=1.

Source files
------------

// File: rtl/weight2_row_loader_pkg.sv
// Shared sizing and state encoding for the
// weight-2 row loader.
package weight2_row_loader_pkg;

  localparam int DW       = 16;
  localparam int ROW_LEN  = 10;
  localparam int NUM_ROWS = 200;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL,
    DONE
  } state_t;

endpackage

// File: rtl/w2_row_bank.sv
// Weight-2 row storage: indexed shadow writes
// and a whole-row copy into the active row.
module w2_row_bank #(
  parameter int DW      = 16,
  parameter int ROW_LEN = 10,
  parameter int WW      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [WW-1:0]         i_wr_idx,
  input  logic [DW-1:0]         i_wr_data,
  input  logic                  i_copy,
  output logic [ROW_LEN*DW-1:0] o_row
);

  logic [ROW_LEN-1:0][DW-1:0] r_shadow;
  logic [ROW_LEN*DW-1:0]      r_active;
  logic [ROW_LEN*DW-1:0]      w_merged;

  // The copy sees the word being written this
  // cycle, so a row completes and goes live at once.
  always_comb begin
    w_merged = '0;
    for (int k = 0; k < ROW_LEN; k++) begin
      if (i_wr_en && (i_wr_idx == WW'(k)))
        w_merged[k*DW +: DW] = i_wr_data;
      else
        w_merged[k*DW +: DW] = r_shadow[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_wr_en)
        r_shadow[i_wr_idx] <= i_wr_data;
      if (i_copy)
        r_active <= w_merged;
    end
  end

  assign o_row = r_active;

endmodule

// File: rtl/weight2_row_loader.sv
// Double-buffered weight-2 row loader: fills a
// shadow row while the consumer uses the active one.
module weight2_row_loader #(
  parameter int DW       = weight2_row_loader_pkg::DW,
  parameter int ROW_LEN  = weight2_row_loader_pkg::ROW_LEN,
  parameter int NUM_ROWS = weight2_row_loader_pkg::NUM_ROWS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  load_next_row,
  output logic                  row_valid,
  output logic [ROW_LEN*DW-1:0] row_data,
  output logic [7:0]            row_index,
  output logic                  done,
  output logic                  err
);

  import weight2_row_loader_pkg::*;

  localparam int WW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int CW = $clog2(NUM_ROWS + 1);

  localparam logic [WW-1:0] WLAST    = WW'(ROW_LEN - 1);
  localparam logic [CW-1:0] NR_C     = CW'(NUM_ROWS);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_ROWS - 1);

  state_t          r_state;
  state_t          w_state_n;
  logic [WW-1:0]   r_wcnt;
  logic [CW-1:0]   r_fetched;
  logic [7:0]      r_idx;
  logic [7:0]      w_idx_n;
  logic            r_run;
  logic            r_err;

  logic            w_ready;
  logic            w_xfer;
  logic            w_fill;
  logic            w_copy;
  logic            w_row_valid;

  assign w_ready = r_run
                && (r_state != FULL)
                && (r_state != DONE)
                && (r_fetched < NR_C);

  assign w_xfer      = in_valid && w_ready;
  assign w_fill      = w_xfer && (r_wcnt == WLAST);
  assign w_row_valid = (r_state == ACTIVE)
                    || (r_state == FULL);

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_copy    = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_fill) begin
          w_state_n = ACTIVE;
          w_copy    = 1'b1;
          // Row 0 keeps index 0; later rows advance.
          if (r_fetched != '0)
            w_idx_n = r_idx + 8'd1;
        end
      end
      ACTIVE: begin
        if (load_next_row) begin
          if (w_fill) begin
            w_copy  = 1'b1;
            w_idx_n = r_idx + 8'd1;
          end else if (r_idx == IDX_LAST) begin
            w_state_n = DONE;
          end else begin
            w_state_n = EMPTY;
          end
        end else if (w_fill) begin
          w_state_n = FULL;
        end
      end
      FULL: begin
        if (load_next_row) begin
          w_state_n = ACTIVE;
          w_copy    = 1'b1;
          w_idx_n   = r_idx + 8'd1;
        end
      end
      DONE: begin
        w_state_n = DONE;
      end
      default: begin
        w_state_n = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= EMPTY;
      r_wcnt    <= '0;
      r_fetched <= '0;
      r_idx     <= '0;
      r_run     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      if (w_xfer)
        r_wcnt <= (r_wcnt == WLAST) ? '0 : r_wcnt + 1'b1;
      if (w_fill)
        r_fetched <= r_fetched + 1'b1;
      if (load_next_row && !w_row_valid)
        r_err <= 1'b1;
    end
  end

  w2_row_bank #(
    .DW      (DW),
    .ROW_LEN (ROW_LEN),
    .WW      (WW)
  ) u_bank (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_wr_en   (w_xfer),
    .i_wr_idx  (r_wcnt),
    .i_wr_data (in_data),
    .i_copy    (w_copy),
    .o_row     (row_data)
  );

  assign in_ready  = w_ready;
  assign row_valid = w_row_valid;
  assign row_index = r_idx;
  assign done      = (r_state == DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_weight2_row_loader.sv
// Randomized bench for weight2_row_loader against
// a queue-based row reference model.
module tb_weight2_row_loader;

  localparam int DW      = 16;
  localparam int ROW_LEN = 10;
  localparam int NR      = 200;
  localparam int RW      = DW * ROW_LEN;

  typedef logic [RW-1:0] row_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          load_next_row = 1'b0;
  logic          row_valid;
  row_t          row_data;
  logic [7:0]    row_index;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  weight2_row_loader #(
    .DW       (DW),
    .ROW_LEN  (ROW_LEN),
    .NUM_ROWS (NR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .load_next_row (load_next_row),
    .row_valid     (row_valid),
    .row_data      (row_data),
    .row_index     (row_index),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string tag,
                     input row_t got,
                     input row_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // Reference model: words collect into a partial
  // row; completed rows queue until presented.
  row_t          m_q[$];
  logic [DW-1:0] m_part[$];
  row_t          m_active;
  bit            m_valid, m_done, m_err, m_run;
  int            m_fetched, m_presented, m_idx;

  function automatic bit m_rdy();
    return m_run && (m_q.size() == 0)
        && (m_fetched < NR) && !m_done;
  endfunction

  task automatic model_edge();
    row_t c;
    bit   have_c;
    have_c = 0;
    c = '0;
    if (!reset) begin
      m_q.delete();
      m_part.delete();
      m_active = '0;
      m_valid = 0; m_done = 0; m_err = 0; m_run = 0;
      m_fetched = 0; m_presented = 0; m_idx = 0;
      return;
    end
    if (in_valid && m_rdy()) begin
      m_part.push_back(in_data);
      if (m_part.size() == ROW_LEN) begin
        for (int k = 0; k < ROW_LEN; k++)
          c[k*DW +: DW] = m_part[k];
        m_part.delete();
        have_c = 1;
        m_fetched++;
      end
    end
    if (load_next_row) begin
      if (m_valid) begin
        m_valid = 0;
        if (m_idx == NR - 1) m_done = 1;
      end else begin
        m_err = 1;
      end
    end
    if (have_c) m_q.push_back(c);
    if (!m_valid && !m_done && m_q.size() > 0) begin
      m_active = m_q.pop_front();
      m_valid = 1;
      m_idx = m_presented;
      m_presented++;
    end
    m_run = 1;
  endtask

  task automatic compare_all();
    chk("in_ready",  row_t'(in_ready),  row_t'(m_rdy()));
    chk("row_valid", row_t'(row_valid), row_t'(m_valid));
    chk("done",      row_t'(done),      row_t'(m_done));
    chk("err",       row_t'(err),       row_t'(m_err));
    chk("row_index", row_t'(row_index), row_t'(m_idx));
    chk("row_data",  row_data,          m_active);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin : main
    row_t          exp;
    int            cyc;
    logic [DW-1:0] w;

    m_q.delete();
    m_part.delete();
    m_active = '0;
    m_valid = 0; m_done = 0; m_err = 0; m_run = 0;
    m_fetched = 0; m_presented = 0; m_idx = 0;

    tick();
    tick();
    chk("rst_in_ready", row_t'(in_ready), '0);
    chk("rst_row_data", row_data, '0);

    reset = 1'b1;
    tick();
    chk("ready_after_rst", row_t'(in_ready), row_t'(1));

    // Row 0: words 1..10 back to back.
    for (int i = 0; i < ROW_LEN; i++) begin
      push_word(DW'(i + 1));
      if (i == ROW_LEN - 2)
        chk("row0_not_yet", row_t'(row_valid), '0);
    end
    for (int k = 0; k < ROW_LEN; k++)
      exp[k*DW +: DW] = DW'(k + 1);
    chk("row0_valid", row_t'(row_valid), row_t'(1));
    chk("row0_data", row_data, exp);
    chk("row0_index", row_t'(row_index), '0);

    // Fill the shadow with no release: FULL.
    for (int i = 0; i < ROW_LEN; i++)
      push_word(DW'(i + 11));
    chk("full_ready", row_t'(in_ready), '0);
    chk("full_keeps_row0", row_data, exp);
    in_valid = 1'b1;
    in_data  = DW'(16'hDEAD);
    tick();
    tick();
    in_valid = 1'b0;

    load_next_row = 1'b1;
    tick();
    load_next_row = 1'b0;
    for (int k = 0; k < ROW_LEN; k++)
      exp[k*DW +: DW] = DW'(k + 11);
    chk("swap_index", row_t'(row_index), row_t'(1));
    chk("swap_valid", row_t'(row_valid), row_t'(1));
    chk("swap_data", row_data, exp);
    chk("swap_ready", row_t'(in_ready), row_t'(1));

    // Release on the same cycle as the last word.
    for (int i = 0; i < ROW_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 21);
      load_next_row = (i == ROW_LEN - 1);
      tick();
      chk("simul_no_bubble", row_t'(row_valid), row_t'(1));
    end
    in_valid = 1'b0;
    load_next_row = 1'b0;
    for (int k = 0; k < ROW_LEN; k++)
      exp[k*DW +: DW] = DW'(k + 21);
    chk("simul_index", row_t'(row_index), row_t'(2));
    chk("simul_data", row_data, exp);

    // Random traffic to the end of the load.
    cyc = 0;
    while (!m_done && cyc < 20000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = DW'($urandom);
      load_next_row = m_valid && ($urandom_range(0, 2) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    load_next_row = 1'b0;
    chk("load_budget", row_t'(cyc < 20000), row_t'(1));
    chk("done_set", row_t'(done), row_t'(1));
    chk("done_ready", row_t'(in_ready), '0);
    chk("done_err", row_t'(err), '0);
    chk("done_index", row_t'(row_index), row_t'(NR - 1));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    load_next_row = 1'b1;
    tick();
    load_next_row = 1'b0;
    chk("done_err_set", row_t'(err), row_t'(1));

    // Reset mid-row 3 after its 5th word.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    cyc = 0;
    while (!(m_fetched == 3 && m_part.size() == 5)
           && cyc < 3000) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = DW'($urandom);
      load_next_row = m_valid && ($urandom_range(0, 1) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    load_next_row = 1'b0;
    chk("midrow_budget", row_t'(cyc < 3000), row_t'(1));
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < ROW_LEN; i++) begin
      w = DW'($urandom);
      exp[i*DW +: DW] = w;
      push_word(w);
    end
    chk("reload_valid", row_t'(row_valid), row_t'(1));
    chk("reload_index", row_t'(row_index), '0);
    chk("reload_data", row_data, exp);
    load_next_row = 1'b1;
    tick();
    chk("release_err", row_t'(err), '0);
    tick();
    load_next_row = 1'b0;
    chk("empty_err", row_t'(err), row_t'(1));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
